hall_decoder: RTL and testbench
===============================

# hall_decoder

Receive-side companion to the brushless commutation logic. It synchronizes and debounces the three Hall-sensor inputs and decodes them into a 0–5 commutation sector. It reports rotation direction, measures the period between sector changes, and flags stall, illegal-code and skipped-sector conditions. The commutation FSM uses its outputs to switch from open-loop stepping to sensor-driven commutation.

## Interface
- `FILTER_LEN`, default 4: consecutive clk cycles a synchronized code must hold before it is accepted (≥1).
- `PERIOD_W`, default 20: width of the period counter and output.
- `TIMEOUT`, default 540000: cycles without an accepted edge before stall is declared (< 2^PERIOD_W).

- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `HS` in 3: raw Hall inputs, asynchronous to clk.
- `clear_fault` in 1: synchronous, one-cycle clear for `fault` and `skip_err`.
- `sector` out 3: decoded sector 0–5.
- `sector_valid` out 1: `sector` reflects a legal current code.
- `dir` out 1: 1 = forward (sector +1 mod 6), 0 = reverse.
- `edge_pulse` out 1: one-cycle strobe when an accepted code change occurs.
- `period` out PERIOD_W: clk cycles between the last two accepted legal edges.
- `period_valid` out 1: `period` is meaningful.
- `stalled` out 1: no accepted edge for TIMEOUT cycles.
- `fault` out 1: sticky; an illegal code (000 or 111) was accepted.
- `skip_err` out 1: sticky; a legal-to-legal transition jumped by 2 or 3 sectors.

## Operation
- Code map: 001→0, 011→1, 010→2, 110→3, 100→4, 101→5. Codes 000 and 111 are illegal.
- `HS` passes through a 2-FF synchronizer, then the debounce filter. The filter counts consecutive cycles in which the synchronized code equals its value on the previous cycle. The code is accepted when the count reaches FILTER_LEN and it differs from the currently accepted code. Any change restarts the count.
- First acceptance after reset has no prior code. A legal code sets `sector` and sets `sector_valid`=1, and pulses `edge_pulse`. `dir`, `period` and `period_valid` are unchanged.
- Legal→legal acceptance:
  - `edge_pulse`=1 and `sector` is updated.
  - Delta of +1 mod 6 sets `dir`=1. Delta of −1 mod 6 sets `dir`=0.
  - Delta of ±2 or 3 sets `skip_err`, leaves `dir` unchanged, and updates `period`.
- Period counter:
  - Counts clk cycles since the last accepted legal edge and saturates at 2^PERIOD_W−1.
  - On a legal edge, `period` ← counter value, then the counter reloads to 1.
  - `period_valid` ← 1 on the second legal edge since reset, stall or illegal code.
- Illegal acceptance:
  - Sets `fault`=1 and `sector_valid`=0, with no `edge_pulse`. `sector` holds its last value and `period_valid`=0.
  - The next legal code behaves as a first acceptance.
- Stall: when the counter reaches TIMEOUT, `stalled`=1 and `period_valid`=0. The next legal acceptance clears `stalled` and behaves as a first acceptance (no `dir` or `period` update).
- `clear_fault` clears `fault` and `skip_err` in the following cycle. If a new fault is detected in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately; the synchronizer flops reset to 000.

## Timing
- Reset values: `sector`=0, `sector_valid`=0, `dir`=1, `edge_pulse`=0, `period`=0, `period_valid`=0, `stalled`=1, `fault`=0, `skip_err`=0.
- All outputs are registered.
- Latency: a clean `HS` change first sampled at edge N gives `edge_pulse` high during the cycle after edge N+FILTER_LEN+2. This is FILTER_LEN+3 cycles. `sector`, `dir` and `period` update in that same cycle.
- `edge_pulse` is high for exactly 1 cycle per accepted change. Accepted changes are at least FILTER_LEN cycles apart.
- Glitches shorter than FILTER_LEN cycles (after synchronization) are never accepted.

## Structure
- Package `hall_pkg`:
  - `sector_t` (logic [2:0]).
  - Constants `HALL_ILLEGAL_0`=3'b000 and `HALL_ILLEGAL_1`=3'b111.
  - Function `hall_to_sector(code)` returning the sector plus a legal flag.
  - Function `sector_delta(prev, next)` returning the mod-6 delta.
- Sub-module `hall_filter` (parameter FILTER_LEN; clk, rst_n, raw[2:0] → code[2:0], code_strobe) holds the synchronizer and debounce.
- The top level holds the decode, direction, period counter, stall and fault logic.

## Test plan
- Forward sequence 001,011,010,110,100,101,001, each held 1000 cycles (FILTER_LEN=4) → sector 0..5,0; `dir`=1; `edge_pulse` 7 times, each 7 cycles after the `HS` change; from the 3rd edge `period`=1000 and `period_valid`=1.
- Reverse sequence 101,100,110 at 500-cycle spacing → `dir`=0 after the 2nd edge; `period`=500.
- 3-cycle glitch 011→010→011 → no `edge_pulse`; `sector` stays 1.
- Code 111 held 10 cycles, then 011 → `fault`=1 and `sector_valid`=0, then 1 with no `period` update; `clear_fault` pulse → `fault`=0 one cycle later.
- Jump 001→110 → `skip_err`=1, `dir` unchanged, `sector`=3.
- No edges for TIMEOUT cycles → `stalled`=1 and `period_valid`=0. Next legal code → `stalled`=0 and `period_valid` stays 0 until one more edge. Assert `rst_n` low mid-sequence → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/hall_pkg.sv
// hall_pkg: shared types, constants and decode helpers for the Hall-sensor
// receive path (hall_filter and hall_decoder).
//   sector_t       : 3-bit commutation sector, legal range 0..5
//   hall_dec_t     : decoded Hall code (legal flag + sector)
//   hall_to_sector : raw 3-bit Hall code -> sector + legal flag
//   sector_delta   : forward distance from prev to next, modulo 6
package hall_pkg;

    typedef logic [2:0] sector_t;

    localparam logic [2:0] HALL_ILLEGAL_0 = 3'b000;
    localparam logic [2:0] HALL_ILLEGAL_1 = 3'b111;

    typedef struct packed {
        logic    legal;
        sector_t sector;
    } hall_dec_t;

    // Sensor order 001,011,010,110,100,101 is one electrical revolution.
    function automatic hall_dec_t hall_to_sector(input logic [2:0] code);
        hall_dec_t res;
        res.legal  = 1'b1;
        res.sector = 3'd0;
        case (code)
            3'b001: res.sector = 3'd0;
            3'b011: res.sector = 3'd1;
            3'b010: res.sector = 3'd2;
            3'b110: res.sector = 3'd3;
            3'b100: res.sector = 3'd4;
            3'b101: res.sector = 3'd5;
            HALL_ILLEGAL_0, HALL_ILLEGAL_1: begin
                res.legal  = 1'b0;
                res.sector = 3'd0;
            end
            default: begin
                res.legal  = 1'b0;
                res.sector = 3'd0;
            end
        endcase
        return res;
    endfunction

    // Result 1 means one step forward, 5 means one step backward.
    function automatic sector_t sector_delta(input sector_t prev, input sector_t next);
        logic [3:0] diff;
        diff = {1'b0, next} + 4'd6 - {1'b0, prev};
        if (diff >= 4'd6) begin
            diff = diff - 4'd6;
        end else begin
            diff = diff;
        end
        return diff[2:0];
    endfunction

endpackage

// File: rtl/hall_filter.sv
// hall_filter: 2-FF synchronizer plus debounce for the raw Hall inputs.
//   clk, rst_n  : clock, async active-low reset
//   raw[2:0]    : asynchronous Hall inputs
//   code[2:0]   : currently accepted (debounced) code
//   code_strobe : one-cycle pulse in the cycle a new code is accepted
// A synchronized code is accepted once it has been held FILTER_LEN cycles
// and differs from the accepted code; the strobe comes FILTER_LEN+1 edges
// after the raw change is first sampled.
module hall_filter
    import hall_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] raw,
    output logic [2:0] code,
    output logic       code_strobe
);

    localparam int              CNT_W   = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN);

    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       acc_q, acc_d;
    logic             strobe_q, strobe_d;

    // Next-state: synchronizer shift, stability count, acceptance.
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        acc_d    = acc_q;
        strobe_d = 1'b0;
        // cnt_q is the number of cycles sync2_q has held its present value.
        if (sync1_q != sync2_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if ((cnt_q == CNT_MAX) && (sync2_q != acc_q)) begin
            acc_d    = sync2_q;
            strobe_d = 1'b1;
        end else begin
            acc_d    = acc_q;
            strobe_d = 1'b0;
        end
    end

    // State registers; synchronizer and accepted code reset to 000.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            cnt_q    <= '0;
            acc_q    <= 3'b000;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
        end
    end

    assign code        = acc_q;
    assign code_strobe = strobe_q;

endmodule

// File: rtl/hall_decoder.sv
// hall_decoder: Hall-sensor receive path for BLDC commutation.
//   clk, rst_n    : clock, async active-low reset
//   HS[2:0]       : raw Hall inputs (asynchronous)
//   clear_fault   : one-cycle clear of fault and skip_err
//   sector        : decoded sector 0..5
//   sector_valid  : sector reflects a legal current code
//   dir           : 1 forward, 0 reverse
//   edge_pulse    : one-cycle strobe per accepted legal change
//   period        : cycles between the last two accepted legal edges
//   period_valid  : period is meaningful
//   stalled       : no accepted legal edge for TIMEOUT cycles
//   fault         : sticky, an illegal code was accepted
//   skip_err      : sticky, a legal transition jumped 2 or 3 sectors
// All outputs are registered.
module hall_decoder
    import hall_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int PERIOD_W   = 20,
    parameter int TIMEOUT    = 540000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          HS,
    input  logic                clear_fault,
    output logic [2:0]          sector,
    output logic                sector_valid,
    output logic                dir,
    output logic                edge_pulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled,
    output logic                fault,
    output logic                skip_err
);

    localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
    localparam logic [PERIOD_W-1:0] CNT_SAT   = {PERIOD_W{1'b1}};

    logic [2:0] code_s;
    logic       strobe_s;

    hall_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw         (HS),
        .code        (code_s),
        .code_strobe (strobe_s)
    );

    hall_dec_t dec_s;
    sector_t   delta_s;
    logic      first_s;
    logic      legal_edge_s;
    logic      illegal_s;
    logic      fault_set_s;
    logic      skip_set_s;

    sector_t             sector_q, sector_d;
    logic                sector_valid_q, sector_valid_d;
    logic                dir_q, dir_d;
    logic                edge_pulse_q, edge_pulse_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic                stalled_q, stalled_d;
    logic                fault_q, fault_d;
    logic                skip_err_q, skip_err_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    assign dec_s        = hall_to_sector(code_s);
    assign delta_s      = sector_delta(sector_q, dec_s.sector);
    // No usable reference sector after reset, an illegal code or a stall.
    assign first_s      = !sector_valid_q || stalled_q;
    assign legal_edge_s = strobe_s && dec_s.legal;
    assign illegal_s    = strobe_s && !dec_s.legal;

    // Next-state for decode, direction, period, stall and sticky flags.
    always_comb begin
        sector_d       = sector_q;
        sector_valid_d = sector_valid_q;
        dir_d          = dir_q;
        edge_pulse_d   = 1'b0;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        stalled_d      = stalled_q;
        fault_set_s    = 1'b0;
        skip_set_s     = 1'b0;

        // Period counter: reload on every legal edge, otherwise saturate.
        if (legal_edge_s) begin
            cnt_d = PERIOD_W'(1);
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (legal_edge_s) begin
            edge_pulse_d   = 1'b1;
            sector_d       = dec_s.sector;
            sector_valid_d = 1'b1;
            stalled_d      = 1'b0;
            if (!first_s) begin
                period_d       = cnt_q;
                period_valid_d = 1'b1;
                case (delta_s)
                    3'd1:             dir_d      = 1'b1;
                    3'd5:             dir_d      = 1'b0;
                    3'd2, 3'd3, 3'd4: skip_set_s = 1'b1;
                    default:          dir_d      = dir_q;
                endcase
            end else begin
                period_d = period_q;
            end
        end else if (illegal_s) begin
            fault_set_s    = 1'b1;
            sector_valid_d = 1'b0;
            period_valid_d = 1'b0;
        end else if (cnt_q >= TIMEOUT_C) begin
            stalled_d      = 1'b1;
            period_valid_d = 1'b0;
        end else begin
            stalled_d = stalled_q;
        end

        // Sticky flags: a new detection beats a simultaneous clear.
        if (fault_set_s) begin
            fault_d = 1'b1;
        end else if (clear_fault) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
        if (skip_set_s) begin
            skip_err_d = 1'b1;
        end else if (clear_fault) begin
            skip_err_d = 1'b0;
        end else begin
            skip_err_d = skip_err_q;
        end
    end

    // Output and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sector_q       <= 3'd0;
            sector_valid_q <= 1'b0;
            dir_q          <= 1'b1;
            edge_pulse_q   <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b1;
            fault_q        <= 1'b0;
            skip_err_q     <= 1'b0;
            cnt_q          <= '0;
        end else begin
            sector_q       <= sector_d;
            sector_valid_q <= sector_valid_d;
            dir_q          <= dir_d;
            edge_pulse_q   <= edge_pulse_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
            fault_q        <= fault_d;
            skip_err_q     <= skip_err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign sector       = sector_q;
    assign sector_valid = sector_valid_q;
    assign dir          = dir_q;
    assign edge_pulse   = edge_pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;
    assign fault        = fault_q;
    assign skip_err     = skip_err_q;

endmodule

// File: tb/tb_hall_decoder.sv
// Directed bench for hall_decoder (FILTER_LEN=4, TIMEOUT=3000).
module tb_hall_decoder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  hs;
    logic        clear_fault;
    logic [2:0]  sector;
    logic        sector_valid;
    logic        dir;
    logic        edge_pulse;
    logic [19:0] period;
    logic        period_valid;
    logic        stalled;
    logic        fault;
    logic        skip_err;

    int checks = 0;
    int errors = 0;

    hall_decoder #(
        .FILTER_LEN (4),
        .PERIOD_W   (20),
        .TIMEOUT    (3000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .HS           (hs),
        .clear_fault  (clear_fault),
        .sector       (sector),
        .sector_valid (sector_valid),
        .dir          (dir),
        .edge_pulse   (edge_pulse),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .fault        (fault),
        .skip_err     (skip_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges, landing 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Flag vector: sector, sector_valid, dir, edge_pulse, period_valid, stalled, fault, skip_err.
    task automatic test_reset();
        rst_n = 1'b0; hs = 3'b000; clear_fault = 1'b0;
        tick(3);
        checks++;
        if ({sector, sector_valid, dir, edge_pulse, period_valid, stalled, fault, skip_err} !== 10'b000_0_1_0_0_1_0_0) begin
            errors++;
            $display("FAIL reset_flags got %b exp %b", {sector, sector_valid, dir, edge_pulse, period_valid, stalled, fault, skip_err}, 10'b000_0_1_0_0_1_0_0);
        end
        checks++;
        if (period !== 20'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", period); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_forward();
        logic [2:0] codes [7];
        logic [2:0] secs  [7];
        codes = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
        secs  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        for (int i = 0; i < 7; i++) begin
            hs = codes[i];
            tick(6);
            checks++;
            if (edge_pulse !== 1'b0) begin errors++; $display("FAIL fwd_early_pulse step %0d got %b exp 0", i, edge_pulse); end
            tick(1);
            checks++;
            if (edge_pulse !== 1'b1) begin errors++; $display("FAIL fwd_pulse step %0d got %b exp 1", i, edge_pulse); end
            checks++;
            if (sector !== secs[i]) begin errors++; $display("FAIL fwd_sector step %0d got %0d exp %0d", i, sector, secs[i]); end
            checks++;
            if ({sector_valid, dir} !== 2'b11) begin errors++; $display("FAIL fwd_valid_dir step %0d got %b exp 11", i, {sector_valid, dir}); end
            if (i >= 1) begin
                checks++;
                if (period_valid !== 1'b1) begin errors++; $display("FAIL fwd_period_valid step %0d got %b exp 1", i, period_valid); end
            end
            if (i >= 2) begin
                checks++;
                if (period !== 20'd1000) begin errors++; $display("FAIL fwd_period step %0d got %0d exp 1000", i, period); end
            end
            tick(1);
            checks++;
            if (edge_pulse !== 1'b0) begin errors++; $display("FAIL fwd_pulse_width step %0d got %b exp 0", i, edge_pulse); end
            tick(992);
        end
    endtask

    task automatic test_reverse();
        logic [2:0]  codes [3];
        logic [2:0]  secs  [3];
        logic [19:0] pers  [3];
        codes = '{3'b101, 3'b100, 3'b110};
        secs  = '{3'd5, 3'd4, 3'd3};
        pers  = '{20'd1000, 20'd500, 20'd500};
        for (int i = 0; i < 3; i++) begin
            hs = codes[i];
            tick(7);
            checks++;
            if ({edge_pulse, dir} !== 2'b10) begin errors++; $display("FAIL rev_pulse_dir step %0d got %b exp 10", i, {edge_pulse, dir}); end
            checks++;
            if (sector !== secs[i]) begin errors++; $display("FAIL rev_sector step %0d got %0d exp %0d", i, sector, secs[i]); end
            checks++;
            if (period !== pers[i]) begin errors++; $display("FAIL rev_period step %0d got %0d exp %0d", i, period, pers[i]); end
            tick(493);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        hs = 3'b010;
        tick(100);
        hs = 3'b011;
        tick(100);
        checks++;
        if ({sector, dir} !== {3'd1, 1'b0}) begin errors++; $display("FAIL glitch_setup got %b exp 0010", {sector, dir}); end
        pulses = 0;
        hs = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (edge_pulse === 1'b1) pulses++;
        end
        hs = 3'b011;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (edge_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", pulses); end
        checks++;
        if ({sector, sector_valid} !== {3'd1, 1'b1}) begin errors++; $display("FAIL glitch_sector got %b exp 0011", {sector, sector_valid}); end
    endtask

    task automatic test_fault();
        hs = 3'b111;
        tick(7);
        checks++;
        if ({fault, sector_valid, edge_pulse, period_valid} !== 4'b1000) begin
            errors++; $display("FAIL fault_flags got %b exp 1000", {fault, sector_valid, edge_pulse, period_valid});
        end
        checks++;
        if (sector !== 3'd1) begin errors++; $display("FAIL fault_sector_hold got %0d exp 1", sector); end
        tick(3);
        hs = 3'b011;
        tick(7);
        checks++;
        if ({edge_pulse, sector_valid, period_valid, fault} !== 4'b1101) begin
            errors++; $display("FAIL fault_recover got %b exp 1101", {edge_pulse, sector_valid, period_valid, fault});
        end
        checks++;
        if (period !== 20'd100) begin errors++; $display("FAIL fault_period_hold got %0d exp 100", period); end
        tick(1);
        clear_fault = 1'b1;
        checks++;
        if (fault !== 1'b1) begin errors++; $display("FAIL fault_before_clear got %b exp 1", fault); end
        tick(1);
        clear_fault = 1'b0;
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b exp 0", fault); end
        tick(91);
    endtask

    task automatic test_skip();
        hs = 3'b001;
        tick(7);
        checks++;
        if ({sector, dir, period_valid, skip_err} !== {3'd0, 3'b010}) begin
            errors++; $display("FAIL skip_pre got %b exp 000010", {sector, dir, period_valid, skip_err});
        end
        checks++;
        if (period !== 20'd100) begin errors++; $display("FAIL skip_pre_period got %0d exp 100", period); end
        tick(93);
        hs = 3'b110;
        tick(7);
        checks++;
        if ({edge_pulse, sector, dir, skip_err} !== {1'b1, 3'd3, 1'b0, 1'b1}) begin
            errors++; $display("FAIL skip_flags got %b exp 101101", {edge_pulse, sector, dir, skip_err});
        end
        checks++;
        if (period !== 20'd100) begin errors++; $display("FAIL skip_period got %0d exp 100", period); end
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        checks++;
        if (skip_err !== 1'b0) begin errors++; $display("FAIL skip_clear got %b exp 0", skip_err); end
    endtask

    task automatic test_stall();
        tick(2989);
        checks++;
        if ({stalled, period_valid} !== 2'b01) begin errors++; $display("FAIL stall_early got %b exp 01", {stalled, period_valid}); end
        tick(20);
        checks++;
        if ({stalled, period_valid} !== 2'b10) begin errors++; $display("FAIL stall_set got %b exp 10", {stalled, period_valid}); end
        hs = 3'b100;
        tick(7);
        checks++;
        if ({edge_pulse, stalled, period_valid, dir} !== 4'b1000) begin
            errors++; $display("FAIL stall_recover got %b exp 1000", {edge_pulse, stalled, period_valid, dir});
        end
        checks++;
        if ({sector, period} !== {3'd4, 20'd100}) begin errors++; $display("FAIL stall_recover_sp got %0d/%0d exp 4/100", sector, period); end
        tick(93);
        hs = 3'b101;
        tick(7);
        checks++;
        if ({sector, dir, period_valid} !== {3'd5, 2'b11}) begin errors++; $display("FAIL stall_next got %b exp 10111", {sector, dir, period_valid}); end
        checks++;
        if (period !== 20'd100) begin errors++; $display("FAIL stall_next_period got %0d exp 100", period); end
    endtask

    task automatic test_reset_mid();
        tick(93);
        hs = 3'b001;
        tick(3);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({sector, sector_valid, dir, edge_pulse, period_valid, stalled, fault, skip_err} !== 10'b000_0_1_0_0_1_0_0) begin
            errors++;
            $display("FAIL midreset_flags got %b exp %b", {sector, sector_valid, dir, edge_pulse, period_valid, stalled, fault, skip_err}, 10'b000_0_1_0_0_1_0_0);
        end
        checks++;
        if (period !== 20'd0) begin errors++; $display("FAIL midreset_period got %0d exp 0", period); end
        tick(3);
        checks++;
        if ({edge_pulse, sector_valid} !== 2'b00) begin errors++; $display("FAIL midreset_hold got %b exp 00", {edge_pulse, sector_valid}); end
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_fault();
        test_skip();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
